// File: rtl/updown_counter_if.sv
// updown_counter_if: control inputs and count/flag outputs of the up/down counter
interface updown_counter_if #(parameter int WIDTH = 4);
  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap_pulse;
  modport master (
    output enable, up_down, clear, load, load_value,
    input  count, at_max, at_min, wrap_pulse
  );
  modport slave (
    input  enable, up_down, clear, load, load_value,
    output count, at_max, at_min, wrap_pulse
  );
endinterface

// File: rtl/updown_counter.sv
// updown_counter: parametrised modulo up/down counter with prescaler, load, clear and wrap flag
module updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 1
) (
  input logic              clock_i,
  input logic              reset_i,
  updown_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);
  logic [WIDTH-1:0] count_q, count_d, stepped, clamped;
  logic             wrap_q, wrap_d, step, hit;
  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE-1);
      logic [PW-1:0] pre_q, pre_d;
      assign step  = bus.enable && pre_q == LAST;
      // prescaler phase restarts on clear/load and wraps after the last enabled cycle
      always_comb pre_d = (bus.clear || bus.load) ? '0 : !bus.enable ? pre_q : step ? '0 : pre_q + 1'b1;
      // prescaler phase register
      always_ff @(posedge clock_i or posedge reset_i)
        if (reset_i) pre_q <= '0;
        else pre_q <= pre_d;
    end else begin : g_nopre
      assign step = bus.enable;
    end
  endgenerate
  assign hit     = bus.up_down ? count_q == MAX : count_q == '0;
  assign clamped = bus.load_value > MAX ? MAX : bus.load_value;
  // next count and wrap flag, priority clear > load > step > hold
  always_comb begin
    stepped = hit ? (SATURATE != 0 ? count_q : bus.up_down ? '0 : MAX)
                  : (bus.up_down ? count_q + 1'b1 : count_q - 1'b1);
    count_d = bus.clear ? '0 : bus.load ? clamped : step ? stepped : count_q;
    wrap_d  = !bus.clear && !bus.load && step && hit && SATURATE == 0;
  end
  // count and wrap pulse registers
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  assign bus.count      = count_q;
  assign bus.at_max     = count_q == MAX;
  assign bus.at_min     = count_q == '0;
  assign bus.wrap_pulse = wrap_q;
endmodule
